// File: rtl/game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// game_flow_ctrl -- round sequencer for the bubble game.
//
// Tracks one round through IDLE -> PLAY -> WIN/LOSE, keeps the round score,
// optionally runs a countdown timer, and builds the status row of cell image
// indices shown along the top of the display.
//
// Optional feature: define GAME_TIMER_EN to build the countdown timer (tick
// divider, timer register, timeout loss, timer digits on the status row).
// Without it the round ends only by score or by a bubble reaching the player,
// tick is tied low and the timer cells stay dark.
//
// Ports
//   clk        in   single clock, all state on the rising edge
//   rst        in   asynchronous active-low reset
//   en         in   start/restart request (level, acted on at its rising edge)
//   pop_cnt    in   bubbles popped this round
//   reach      in   a bubble reached the player row (loss)
//   score_row  out  status row, cell 0 in the MSBs
//   state      out  0 IDLE, 1 PLAY, 2 WIN, 3 LOSE (also the FSM debug view)
//   playing    out  high in PLAY
//   finish     out  high in WIN or LOSE
//   tick       out  one-cycle pulse per timer tick while playing
//
// All outputs are registered; each is computed from the next-state values so
// that state, flags and status row always change on the same clock edge.
// There is no valid/ready handshake: outputs are level signals valid every
// cycle after the edge that produced them.
// ---------------------------------------------------------------------------
module game_flow_ctrl #(
   parameter int NUM_COLS     = 8,
   parameter int CELL_W       = 5,
   parameter int CNT_W        = 7,
   parameter int SCORE_TARGET = 40,
   parameter int TIME_LIMIT   = 60,
   parameter int TICK_DIV     = 100000000
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         en,
   input  logic [CNT_W-1:0]             pop_cnt,
   input  logic                         reach,
   output logic [NUM_COLS*CELL_W-1:0]   score_row,
   output logic [1:0]                   state,
   output logic                         playing,
   output logic                         finish,
   output logic                         tick
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_WIN  = 2'd2,
      ST_LOSE = 2'd3
   } state_e;

   localparam int                ROW_W     = NUM_COLS * CELL_W;
   localparam logic [CELL_W-1:0] CELL_DARK = CELL_W'(31);
   localparam logic [CELL_W-1:0] CELL_WIN  = CELL_W'(16);  // bubble colour 1
   localparam logic [CELL_W-1:0] CELL_LOSE = CELL_W'(10);  // player colour 1
   localparam logic [31:0]       TARGET_U  = 32'(SCORE_TARGET);

   state_e               state_q, state_d;
   logic                 en_q, en_vld_q, en_rise;
   logic [31:0]          pop_ext;
   logic [9:0]           score_sat, score_q, score_d;
   logic                 win_cond, timeout, enter_play, tick_d;
   logic [CELL_W-1:0]    tmr_tens, tmr_ones;
   logic [ROW_W-1:0]     score_row_q, score_row_d;
   logic                 playing_q, finish_q, tick_q;

   // en_vld_q stays low for the first edge after reset so that an en held
   // high across reset release is seen as a level, not as a new request.
   assign en_rise   = en & ~en_q & en_vld_q;
   assign pop_ext   = 32'(pop_cnt);
   assign score_sat = (pop_ext > 32'd999) ? 10'd999 : pop_ext[9:0];
   assign win_cond  = (pop_ext >= TARGET_U);

   // ---------------------------------------------------------------- FSM ---
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE, ST_WIN, ST_LOSE: begin
            if (en_rise) state_d = ST_PLAY;
         end
         ST_PLAY: begin
            // win is checked first so a simultaneous loss cannot override it
            if (win_cond)              state_d = ST_WIN;
            else if (reach || timeout) state_d = ST_LOSE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign enter_play = (state_q != ST_PLAY) && (state_d == ST_PLAY);

   // Score follows pop_cnt while playing (including the cycle that ends the
   // round) and then holds until the next round starts.
   always_comb begin
      score_d = score_q;
      if (enter_play)               score_d = 10'd0;
      else if (state_q == ST_PLAY)  score_d = score_sat;
   end

   // -------------------------------------------------------------- timer ---
`ifdef GAME_TIMER_EN
   localparam int                DIV_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [6:0]       timer_q, timer_d;
   logic             tick_wrap;

   always_comb begin
      tick_wrap = (state_q == ST_PLAY) && (cnt_q == DIV_LAST);
      cnt_d     = cnt_q;
      timer_d   = timer_q;
      if (enter_play) begin
         cnt_d   = '0;
         timer_d = 7'(TIME_LIMIT);
      end else if (state_q == ST_PLAY) begin
         cnt_d = tick_wrap ? '0 : cnt_q + DIV_W'(1);
         if (tick_wrap && (timer_q != 7'd0)) timer_d = timer_q - 7'd1;
      end
      timeout  = (timer_q == 7'd0);
      tick_d   = tick_wrap;
      tmr_tens = CELL_W'(timer_d / 7'd10);
      tmr_ones = CELL_W'(timer_d % 7'd10);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         timer_q <= 7'(TIME_LIMIT);
      end else begin
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
      end
   end
`else
   assign timeout  = 1'b0;
   assign tick_d   = 1'b0;
   assign tmr_tens = CELL_DARK;
   assign tmr_ones = CELL_DARK;
`endif

   // --------------------------------------------------------- status row ---
   always_comb begin
      score_row_d = {NUM_COLS{CELL_DARK}};
      if (state_d != ST_IDLE) begin
         score_row_d[ROW_W-1          -: CELL_W] = CELL_W'(score_d / 10'd100);
         score_row_d[ROW_W-1-CELL_W   -: CELL_W] = CELL_W'((score_d / 10'd10) % 10'd10);
         score_row_d[ROW_W-1-2*CELL_W -: CELL_W] = CELL_W'(score_d % 10'd10);
         if (state_d == ST_WIN)
            score_row_d[ROW_W-1-3*CELL_W -: CELL_W] = CELL_WIN;
         else if (state_d == ST_LOSE)
            score_row_d[ROW_W-1-3*CELL_W -: CELL_W] = CELL_LOSE;
         score_row_d[2*CELL_W-1 -: CELL_W] = tmr_tens;
         score_row_d[CELL_W-1   -: CELL_W] = tmr_ones;
      end
   end

   // ---------------------------------------------------------- registers ---
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         en_q        <= 1'b0;
         en_vld_q    <= 1'b0;
         score_q     <= 10'd0;
         score_row_q <= {NUM_COLS{CELL_DARK}};
         playing_q   <= 1'b0;
         finish_q    <= 1'b0;
         tick_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         en_q        <= en;
         en_vld_q    <= 1'b1;
         score_q     <= score_d;
         score_row_q <= score_row_d;
         playing_q   <= (state_d == ST_PLAY);
         finish_q    <= (state_d == ST_WIN) || (state_d == ST_LOSE);
         tick_q      <= tick_d;
      end
   end

   assign score_row = score_row_q;
   assign state     = state_q;
   assign playing   = playing_q;
   assign finish    = finish_q;
   assign tick      = tick_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_flow_ctrl -- directed bench for game_flow_ctrl with a small divider
// (TICK_DIV=4, TIME_LIMIT=3, SCORE_TARGET=5).
//
// The driver applies input vectors and pushes the output word it expects at
// the next visible output change (or at an explicit probe during quiet
// periods). The monitor watches the outputs on every falling edge; whenever
// they change, or a probe is pending, it pops one expectation and compares.
// Some expectations also carry the number of cycles since the previous
// output event, which pins down the tick spacing.
// Expectations adapt to whether GAME_TIMER_EN is defined.
// ---------------------------------------------------------------------------
module tb_game_flow_ctrl;

   localparam int NC   = 8;
   localparam int CW   = 5;
   localparam int CNTW = 7;
   localparam int TGT  = 5;
   localparam int TL   = 3;
   localparam int TD   = 4;
   localparam int OW   = 5 + NC * CW;
`ifdef GAME_TIMER_EN
   localparam bit TMR = 1'b1;
`else
   localparam bit TMR = 1'b0;
`endif

   logic              clk, rst, en, reach;
   logic [CNTW-1:0]   pop_cnt;
   logic [NC*CW-1:0]  score_row;
   logic [1:0]        state;
   logic              playing, finish, tick;

   game_flow_ctrl #(
      .NUM_COLS(NC), .CELL_W(CW), .CNT_W(CNTW),
      .SCORE_TARGET(TGT), .TIME_LIMIT(TL), .TICK_DIV(TD)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .pop_cnt(pop_cnt), .reach(reach),
      .score_row(score_row), .state(state), .playing(playing),
      .finish(finish), .tick(tick)
   );

   // ------------------------------------------------------ clock / reset ---
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // --------------------------------------------------------- scoreboard ---
   logic [OW-1:0] exp_q[$];
   int            gap_q[$];
   string         name_q[$];
   int            n_chk = 0;
   int            n_pass = 0;
   int            probe_cnt = 0;
   int            probe_seen = 0;

   // Expected output word {state, playing, finish, tick, score_row}.
   function automatic logic [OW-1:0] mk(input int st, input int sc, input int tm, input bit tk);
      logic [NC*CW-1:0] row;
      logic [1:0]       s2;
      logic             pl, fi, tb;
      int               val;
      for (int c = 0; c < NC; c++) begin
         val = 31;
         if (st != 0) begin
            if (c == 0) val = sc / 100;
            if (c == 1) val = (sc / 10) % 10;
            if (c == 2) val = sc % 10;
            if (c == 3) val = (st == 2) ? 16 : ((st == 3) ? 10 : 31);
            if (TMR && c == NC - 2) val = tm / 10;
            if (TMR && c == NC - 1) val = tm % 10;
         end
         row[(NC-1-c)*CW +: CW] = val[CW-1:0];
      end
      s2 = st[1:0];
      pl = (st == 1);
      fi = (st >= 2);
      tb = tk & TMR;
      return {s2, pl, fi, tb, row};
   endfunction

   task automatic push(input logic [OW-1:0] v, input int gap, input string nm);
      exp_q.push_back(v);
      gap_q.push_back(gap);
      name_q.push_back(nm);
   endtask

   // Checks the outputs at the next falling edge even if nothing changed.
   task automatic probe(input logic [OW-1:0] v, input string nm);
      push(v, 0, nm);
      probe_cnt++;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ------------------------------------------------------------ monitor ---
   initial begin
      logic [OW-1:0] prev, obs, e;
      int            neg_n, last_neg, g;
      string         nm;
      prev     = 'x;
      neg_n    = 0;
      last_neg = 0;
      forever begin
         @(negedge clk);
         neg_n++;
         obs = {state, playing, finish, tick, score_row};
         if (obs !== prev || probe_cnt != probe_seen) begin
            probe_seen = probe_cnt;
            n_chk++;
            if (exp_q.size() == 0) begin
               $display("FAIL unexpected_change: got %h, required no change", obs);
            end else begin
               e  = exp_q.pop_front();
               g  = gap_q.pop_front();
               nm = name_q.pop_front();
               if (obs === e) n_pass++;
               else $display("FAIL %s: got state=%0d row=%h flags=%b, required state=%0d row=%h flags=%b",
                             nm, obs[OW-1 -: 2], obs[NC*CW-1:0], obs[OW-3 -: 3],
                             e[OW-1 -: 2], e[NC*CW-1:0], e[OW-3 -: 3]);
               if (g != 0) begin
                  n_chk++;
                  if (neg_n - last_neg == g) n_pass++;
                  else $display("FAIL %s_gap: got %0d cycles, required %0d", nm, neg_n - last_neg, g);
               end
            end
            last_neg = neg_n;
            prev     = obs;
         end
      end
   end

   // ------------------------------------------------------------- driver ---
   initial begin
      logic [OW-1:0] e;
      string         nm;
      rst = 1'b1; en = 1'b0; pop_cnt = '0; reach = 1'b0;
      #1 rst = 1'b0;
      push(mk(0, 0, TL, 0), 0, "reset_state");
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;

      // start, score ramp to target, win
      step(); en = 1'b1;
      push(mk(1, 0, 3, 0), 0, "start_play");
      for (int k = 1; k <= 4; k++) begin
         step(); pop_cnt = CNTW'(k);
         push(mk(1, k, (k == 4) ? 2 : 3, (k == 4)), 0, "score_ramp");
      end
      step(); pop_cnt = CNTW'(5);
      push(mk(2, 5, 2, 0), 0, "win");
      repeat (6) step();
      probe(mk(2, 5, 2, 0), "win_hold_en_high");

      // restart, then let the timer run out
      step(); en = 1'b0; pop_cnt = '0;
      step(); en = 1'b1;
      push(mk(1, 0, 3, 0), 0, "restart");
`ifdef GAME_TIMER_EN
      push(mk(1, 0, 2, 1), 4, "tick1");
      push(mk(1, 0, 2, 0), 1, "tick1_end");
      push(mk(1, 0, 1, 1), 3, "tick2");
      push(mk(1, 0, 1, 0), 1, "tick2_end");
      push(mk(1, 0, 0, 1), 3, "tick3");
      push(mk(3, 0, 0, 0), 1, "timeout_lose");
`endif
      repeat (20) step();
`ifdef GAME_TIMER_EN
      probe(mk(3, 0, 0, 0), "lose_hold");
`else
      probe(mk(1, 0, 3, 0), "no_timeout");
      push(mk(3, 0, 3, 0), 0, "reach_lose");
`endif
      reach = 1'b1;
      step(); reach = 1'b0;
      repeat (3) step();

      // replay; en edge in PLAY ignored; win beats reach in the same cycle
      step(); en = 1'b0;
      step(); en = 1'b1;
      push(mk(1, 0, 3, 0), 0, "replay");
      step(); en = 1'b0;
      step(); en = 1'b1;
      step();
      probe(mk(1, 0, 3, 0), "en_in_play_ignored");
      pop_cnt = CNTW'(5); reach = 1'b1;
      push(mk(2, 5, 3, 0), 0, "win_priority");
      step(); reach = 1'b0; pop_cnt = '0;
      repeat (4) step();
      probe(mk(2, 5, 3, 0), "win_frozen");

      // asynchronous reset in the middle of a round, en held across release
      step(); en = 1'b0;
      step(); en = 1'b1;
      push(mk(1, 0, 3, 0), 0, "play_before_reset");
      step(); pop_cnt = CNTW'(3);
      push(mk(1, 3, 3, 0), 0, "score3");
      step();
      @(posedge clk);
      push(mk(0, 0, 3, 0), 0, "async_reset");
      #2 rst = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      repeat (6) step();
      probe(mk(0, 0, 3, 0), "idle_after_release");
      step(); en = 1'b0; pop_cnt = '0;
      step(); en = 1'b1;
      push(mk(1, 0, 3, 0), 0, "play_after_reset");
      repeat (3) step();

      // drain: anything still queued was never presented by the DUT
      for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
      while (exp_q.size() != 0) begin
         n_chk++;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         void'(gap_q.pop_front());
         $display("FAIL %s: got no output event, required %h", nm, e);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
